axi_lite_reg_slv: RTL and testbench

- AXI4-Lite responder (slave endpoint) that terminates transactions arriving from a crossbar master port into a bank of NoRegs memory-mapped registers.
- Registers are readable and writable over the bus, with byte strobes. Each register is exposed to hardware and can be loaded by hardware.
- Write and read paths are independent FSMs; each has one transaction in flight.

---
 rtl/axi_lite_reg_slv.sv | 208 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slv.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slv.sv
// AXI4-Lite responder terminating into NoRegs byte-strobed registers with per-register hardware load.
// Optional macro AXI_LITE_REG_SLV_ERR_EN: SLVERR for out-of-range accesses and writes to read-only registers.
module axi_lite_reg_slv #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NoRegs    = 16,
    parameter logic [DataWidth-1:0] RegRstVal = '0,
    parameter logic [NoRegs-1:0]    ReadOnly  = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [AddrWidth-1:0]        aw_addr_i,
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [DataWidth-1:0]        w_data_i,
    input  logic [DataWidth/8-1:0]      w_strb_i,
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    output logic [1:0]                  b_resp_o,
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    input  logic [AddrWidth-1:0]        ar_addr_i,
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    output logic [DataWidth-1:0]        r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    input  logic [NoRegs-1:0]           reg_load_i,
    input  logic [NoRegs*DataWidth-1:0] reg_d_i,
    output logic [NoRegs*DataWidth-1:0] reg_q_o
);
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned ByteLsb    = $clog2(StrbWidth);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
`ifdef AXI_LITE_REG_SLV_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e              wr_state_reg, wr_state_next;
    rd_state_e              rd_state_reg, rd_state_next;
    logic                   rdy_en_reg;
    logic                   aw_held_reg, aw_held_next;
    logic                   w_held_reg, w_held_next;
    logic [AddrWidth-1:0]   aw_addr_reg, aw_addr_next;
    logic [DataWidth-1:0]   w_data_reg, w_data_next;
    logic [StrbWidth-1:0]   w_strb_reg, w_strb_next;
    logic [1:0]             b_resp_reg, b_resp_next;
    logic [DataWidth-1:0]   r_data_reg, r_data_next;
    logic [1:0]             r_resp_reg, r_resp_next;

    logic                   aw_hs, w_hs, ar_hs, wr_commit;
    logic [AddrWidth-1:0]   wr_addr, wr_idx, rd_idx;
    logic [DataWidth-1:0]   wr_data, rd_mux;
    logic [StrbWidth-1:0]   wr_strb;
    logic [NoRegs-1:0]      wr_dec, rd_dec, wr_sel;

    // Readies stay low until the first edge after reset release.
    assign aw_ready_o = rdy_en_reg && (wr_state_reg == WR_IDLE) && !aw_held_reg;
    assign w_ready_o  = rdy_en_reg && (wr_state_reg == WR_IDLE) && !w_held_reg;
    assign ar_ready_o = rdy_en_reg && (rd_state_reg == RD_IDLE);
    assign b_valid_o  = (wr_state_reg == WR_RESP);
    assign b_resp_o   = b_resp_reg;
    assign r_valid_o  = (rd_state_reg == RD_RESP);
    assign r_data_o   = r_data_reg;
    assign r_resp_o   = r_resp_reg;

    assign aw_hs     = aw_valid_i && aw_ready_o;
    assign w_hs      = w_valid_i && w_ready_o;
    assign ar_hs     = ar_valid_i && ar_ready_o;
    assign wr_commit = (wr_state_reg == WR_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_addr   = aw_held_reg ? aw_addr_reg : aw_addr_i;
    assign wr_data   = w_held_reg ? w_data_reg : w_data_i;
    assign wr_strb   = w_held_reg ? w_strb_reg : w_strb_i;
    assign wr_idx    = wr_addr >> ByteLsb;
    assign rd_idx    = ar_addr_i >> ByteLsb;
    assign wr_sel    = wr_commit ? (wr_dec & ~ReadOnly) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NoRegs; gi++) begin : g_reg
            logic [DataWidth-1:0] q_reg, q_next;

            assign wr_dec[gi] = (wr_idx == AddrWidth'(gi));
            assign rd_dec[gi] = (rd_idx == AddrWidth'(gi));

            // Hardware load first, then strobed bus bytes override it.
            always_comb begin
                q_next = reg_load_i[gi] ? reg_d_i[gi*DataWidth +: DataWidth] : q_reg;
                for (int b = 0; b < StrbWidth; b++) begin
                    if (wr_sel[gi] && wr_strb[b]) begin
                        q_next[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    q_reg <= RegRstVal;
                end else begin
                    q_reg <= q_next;
                end
            end

            assign reg_q_o[gi*DataWidth +: DataWidth] = q_reg;
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NoRegs; k++) begin
            if (rd_dec[k]) begin
                rd_mux = rd_mux | reg_q_o[k*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_en_reg   <= 1'b0;
            wr_state_reg <= WR_IDLE;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            b_resp_reg   <= RespOkay;
            rd_state_reg <= RD_IDLE;
            r_data_reg   <= '0;
            r_resp_reg   <= RespOkay;
        end else begin
            rdy_en_reg   <= 1'b1;
            wr_state_reg <= wr_state_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            aw_addr_reg  <= aw_addr_next;
            w_data_reg   <= w_data_next;
            w_strb_reg   <= w_strb_next;
            b_resp_reg   <= b_resp_next;
            rd_state_reg <= rd_state_next;
            r_data_reg   <= r_data_next;
            r_resp_reg   <= r_resp_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        aw_held_next  = aw_held_reg;
        w_held_next   = w_held_reg;
        aw_addr_next  = aw_addr_reg;
        w_data_next   = w_data_reg;
        w_strb_next   = w_strb_reg;
        b_resp_next   = b_resp_reg;
        case (wr_state_reg)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_next = 1'b1;
                    aw_addr_next = aw_addr_i;
                end
                if (w_hs) begin
                    w_held_next = 1'b1;
                    w_data_next = w_data_i;
                    w_strb_next = w_strb_i;
                end
                if (wr_commit) begin
                    wr_state_next = WR_RESP;
                    // No writable register decoded means out-of-range or read-only.
                    b_resp_next = (ErrEn && ((wr_dec & ~ReadOnly) == '0)) ? RespSlvErr : RespOkay;
                end
            end
            WR_RESP: begin
                if (b_ready_i) begin
                    wr_state_next = WR_IDLE;
                    aw_held_next  = 1'b0;
                    w_held_next   = 1'b0;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        r_data_next   = r_data_reg;
        r_resp_next   = r_resp_reg;
        case (rd_state_reg)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_next = RD_RESP;
                    r_data_next   = rd_mux;
                    r_resp_next   = (ErrEn && (rd_dec == '0)) ? RespSlvErr : RespOkay;
                end
            end
            RD_RESP: begin
                if (r_ready_i) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_reg_slv.sv
// Randomized self-checking bench for axi_lite_reg_slv against a byte-level register model.
module tb_axi_lite_reg_slv;
    localparam int          NR = 16;
    localparam logic [NR-1:0] RO = 16'h0008;
`ifdef AXI_LITE_REG_SLV_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [31:0]       aw_addr_i = '0;
    logic              aw_valid_i = 1'b0;
    logic              aw_ready_o;
    logic [31:0]       w_data_i = '0;
    logic [3:0]        w_strb_i = '0;
    logic              w_valid_i = 1'b0;
    logic              w_ready_o;
    logic [1:0]        b_resp_o;
    logic              b_valid_o;
    logic              b_ready_i = 1'b0;
    logic [31:0]       ar_addr_i = '0;
    logic              ar_valid_i = 1'b0;
    logic              ar_ready_o;
    logic [31:0]       r_data_o;
    logic [1:0]        r_resp_o;
    logic              r_valid_o;
    logic              r_ready_i = 1'b0;
    logic [NR-1:0]     reg_load_i = '0;
    logic [NR*32-1:0]  reg_d_i = '0;
    logic [NR*32-1:0]  reg_q_o;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model_regs [NR];

    axi_lite_reg_slv #(
        .AddrWidth (32),
        .DataWidth (32),
        .NoRegs    (NR),
        .RegRstVal (32'h0),
        .ReadOnly  (RO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .b_resp_o   (b_resp_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .ar_addr_i  (ar_addr_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .reg_load_i (reg_load_i),
        .reg_d_i    (reg_d_i),
        .reg_q_o    (reg_q_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input bit err);
        return (ErrEn && err) ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
    endfunction

    function automatic void model_load(input logic [NR-1:0] mask, input logic [31:0] val);
        for (int k = 0; k < NR; k++) if (mask[k]) model_regs[k] = val;
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++)
            check_eq($sformatf("%s_reg%0d", tag, k), reg_q_o[k*32 +: 32], model_regs[k]);
    endtask

    // Write with AW/W presented at independent cycle offsets; ld_mask loads land in the commit cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_off, input int w_off, input int b_wait,
                            input logic [NR-1:0] ld_mask, input logic [31:0] ld_val,
                            output logic [1:0] resp_seen);
        bit          aw_done = 0, w_done = 0, aw_go, w_go, err;
        int          t = 0;
        logic [31:0] idx;
        logic [1:0]  exp_b;
        aw_addr_i = addr;
        w_data_i  = data;
        w_strb_i  = strb;
        while (!(aw_done && w_done) && t < 40) begin
            aw_valid_i = !aw_done && (t >= aw_off);
            w_valid_i  = !w_done && (t >= w_off);
            @(negedge clk_i);
            check_eq("aw_ready_idle", aw_ready_o, !aw_done);
            check_eq("w_ready_idle", w_ready_o, !w_done);
            aw_go = aw_valid_i && aw_ready_o;
            w_go  = w_valid_i && w_ready_o;
            if ((aw_done || aw_go) && (w_done || w_go)) begin
                reg_load_i = ld_mask;
                reg_d_i    = {NR{ld_val}};
            end
            @(posedge clk_i); #1;
            reg_load_i = '0;
            aw_done = aw_done || aw_go;
            w_done  = w_done || w_go;
            t++;
        end
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b0;
        check_eq("wr_handshakes", {aw_done, w_done}, 2'b11);
        model_load(ld_mask, ld_val);
        idx = addr >> 2;
        err = !(idx < NR && !RO[idx]);
        if (!err)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        exp_b = exp_resp(err);
        check_eq("b_valid_first", b_valid_o, 1'b1);
        repeat (b_wait) begin
            aw_valid_i = 1'b1;
            w_valid_i  = 1'b1;
            aw_addr_i  = $urandom;
            @(negedge clk_i);
            check_eq("b_valid_hold", b_valid_o, 1'b1);
            check_eq("aw_ready_resp", aw_ready_o, 1'b0);
            check_eq("w_ready_resp", w_ready_o, 1'b0);
            @(posedge clk_i); #1;
        end
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b0;
        b_ready_i  = 1'b1;
        @(negedge clk_i);
        resp_seen = b_resp_o;
        check_eq("b_resp", b_resp_o, exp_b);
        @(posedge clk_i); #1;
        b_ready_i = 1'b0;
        check_eq("b_valid_clear", b_valid_o, 1'b0);
        check_regs("wr");
        $display("WR addr=%08h data=%08h strb=%h ld=%04h resp=%0d", addr, data, strb, ld_mask, resp_seen);
    endtask

    // Read; ld_mask loads land in the AR handshake cycle and must not affect the returned data.
    task automatic do_read(input logic [31:0] addr, input int r_wait,
                           input logic [NR-1:0] ld_mask, input logic [31:0] ld_val,
                           output logic [31:0] data_seen);
        bit          hs = 0;
        int          t = 0;
        logic [31:0] idx, exp_d;
        logic [1:0]  exp_r;
        idx        = addr >> 2;
        exp_d      = (idx < NR) ? model_regs[idx] : 32'h0;
        exp_r      = exp_resp(idx >= NR);
        ar_addr_i  = addr;
        ar_valid_i = 1'b1;
        while (!hs && t < 20) begin
            @(negedge clk_i);
            hs = ar_ready_o;
            if (hs) begin
                reg_load_i = ld_mask;
                reg_d_i    = {NR{ld_val}};
            end
            @(posedge clk_i); #1;
            reg_load_i = '0;
            t++;
        end
        ar_valid_i = 1'b0;
        check_eq("ar_handshake", hs, 1'b1);
        if (hs) model_load(ld_mask, ld_val);
        data_seen = r_data_o;
        check_eq("r_valid_first", r_valid_o, 1'b1);
        check_eq("r_data", r_data_o, exp_d);
        check_eq("r_resp", r_resp_o, exp_r);
        repeat (r_wait) begin
            ar_valid_i = 1'b1;
            @(negedge clk_i);
            check_eq("r_valid_hold", r_valid_o, 1'b1);
            check_eq("r_data_hold", r_data_o, exp_d);
            check_eq("ar_ready_resp", ar_ready_o, 1'b0);
            @(posedge clk_i); #1;
        end
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        @(posedge clk_i); #1;
        r_ready_i = 1'b0;
        check_eq("r_valid_clear", r_valid_o, 1'b0);
        $display("RD addr=%08h data=%08h ld=%04h resp=%0d", addr, data_seen, ld_mask, exp_r);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata, addr;
        model_reset();

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_b_valid", b_valid_o, 1'b0);
        check_eq("rst_r_valid", r_valid_o, 1'b0);
        check_eq("rst_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        check_eq("rst_resps", {b_resp_o, r_resp_o}, 4'h0);
        check_eq("rst_r_data", r_data_o, 32'h0);
        check_regs("rst");
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("post_rst_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
        $display("RESET released");

        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, '0, '0, resp);
        check_eq("simul_reg2", reg_q_o[2*32 +: 32], 32'hDEADBEEF);
        check_eq("simul_resp", resp, 2'b00);
        do_read(32'h8, 0, '0, '0, rdata);
        check_eq("simul_rd", rdata, 32'hDEADBEEF);

        do_write(32'h4, 32'h11223344, 4'h5, 3, 0, 4, '0, '0, resp);
        check_eq("strb_reg1", reg_q_o[1*32 +: 32], 32'h00220044);

        do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 1, '0, '0, resp);
        check_eq("ro_reg3", reg_q_o[3*32 +: 32], 32'h0);
        check_eq("ro_resp", resp, ErrEn ? 2'b10 : 2'b00);

        do_read(32'h40, 2, '0, '0, rdata);
        check_eq("oor_rd", rdata, 32'h0);

        do_write(32'h0, 32'h000000BB, 4'h1, 0, 0, 0, 16'h0001, 32'hAAAAAAAA, resp);
        check_eq("collide_reg0", reg_q_o[0 +: 32], 32'hAAAAAABB);

        do_read(32'h0, 1, 16'h0001, 32'h12345678, rdata);
        check_eq("rd_old_value", rdata, 32'hAAAAAABB);

        for (int i = 0; i < 40; i++) begin
            addr = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0, $urandom, resp);
            else
                do_read(addr, $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0, $urandom, rdata);
        end

        aw_addr_i  = 32'h10;
        w_data_i   = 32'hCAFEF00D;
        w_strb_i   = 4'hF;
        ar_addr_i  = 32'h10;
        aw_valid_i = 1'b1;
        w_valid_i  = 1'b1;
        ar_valid_i = 1'b1;
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b0;
        ar_valid_i = 1'b0;
        check_eq("mid_b_valid", b_valid_o, 1'b1);
        check_eq("mid_r_valid", r_valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("async_b_valid", b_valid_o, 1'b0);
        check_eq("async_r_valid", r_valid_o, 1'b0);
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            check_eq("post_rst_no_b", b_valid_o, 1'b0);
            check_eq("post_rst_no_r", r_valid_o, 1'b0);
        end
        check_regs("mid_rst");
        $display("RESET mid-transaction");
        do_write(32'h14, 32'h0BADCAFE, 4'hF, 1, 0, 0, '0, '0, resp);
        do_read(32'h14, 0, '0, '0, rdata);
        check_eq("after_rst_rd", rdata, 32'h0BADCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
